// File: rtl/spmi_pkg.sv
`timescale 1ns / 100ps
// spmi_pkg: shared constants and types for the SPMI receiver front-end.
//   FRAME_BITS        - bits per received frame (SA + command + parity)
//   SA_*, CMD_*, PAR  - field positions inside the 13-bit packet
//   state_e           - receiver FSM states
package spmi_pkg;

    localparam int unsigned FRAME_BITS = 13;

    localparam int unsigned SA_MSB  = 12;
    localparam int unsigned SA_LSB  = 9;
    localparam int unsigned CMD_MSB = 8;
    localparam int unsigned CMD_LSB = 1;
    localparam int unsigned PAR_BIT = 0;

    typedef enum logic [1:0] {
        IDLE,
        SSC_HI,
        RECV
    } state_e;

endpackage

// File: rtl/spmi_sync.sv
`timescale 1ns / 100ps
// spmi_sync: SYNC_STAGES-deep flip-flop synchronizer for one asynchronous bit.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears every stage
//   d     - asynchronous input
//   q     - synchronized output
module spmi_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages_q <= '0;
        end else begin
            stages_q[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stages_q[i] <= stages_q[i-1];
            end
        end
    end

    assign q = stages_q[SYNC_STAGES-1];

endmodule

// File: rtl/spmi.sv
`timescale 1ns / 100ps
// spmi: SPMI bus receiver front-end. Oversamples spmiclk/spmidat in the sysclk
// domain, detects the Sequence Start Condition and shifts in one 13-bit frame
// (SA[3:0], command[7:0], parity), then hands it to a single holding register.
//   sysclk   - system clock
//   reset    - asynchronous active-low reset
//   spmiclk  - SPMI clock (asynchronous)
//   spmidat  - SPMI data (asynchronous)
//   fetched  - one-cycle consumer acknowledge, releases the holding register
//   packet   - held frame, MSB first as received
//   valid    - packet holds an unconsumed frame
//   overflow - a completed frame was dropped because packet was still full
module spmi
    import spmi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                  sysclk,
    input  logic                  reset,
    input  logic                  spmiclk,
    input  logic                  spmidat,
    input  logic                  fetched,
    output logic [FRAME_BITS-1:0] packet,
    output logic                  valid,
    output logic                  overflow
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic clk_s, dat_s;
    logic clk_prev_q, dat_prev_q;
    logic clk_rise, dat_rise, dat_fall;

    state_e                state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  frame_done;

    logic [FRAME_BITS-1:0] packet_q, packet_d;
    logic                  valid_q, valid_d;
    logic                  overflow_q, overflow_d;

    spmi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk   (sysclk),
        .rst_n (reset),
        .d     (spmiclk),
        .q     (clk_s)
    );

    spmi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dat (
        .clk   (sysclk),
        .rst_n (reset),
        .d     (spmidat),
        .q     (dat_s)
    );

    assign clk_rise = clk_s & ~clk_prev_q;
    assign dat_rise = dat_s & ~dat_prev_q;
    assign dat_fall = ~dat_s & dat_prev_q;

    // Receiver FSM, shifter and mid-frame timeout
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        timer_d    = timer_q;
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dat_rise && !clk_s) begin
                    state_d = SSC_HI;
                end
            end
            SSC_HI: begin
                // A clock edge before data falls means a malformed SSC
                if (clk_rise) begin
                    state_d = IDLE;
                end else if (dat_fall && !clk_s) begin
                    state_d   = RECV;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    timer_d   = '0;
                end
            end
            RECV: begin
                if (clk_rise) begin
                    shift_d   = {shift_q[FRAME_BITS-2:0], dat_s};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    timer_d   = '0;
                    if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
                        frame_done = 1'b1;
                        state_d    = IDLE;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    // Partial frame is silently discarded
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Holding register; fetched on the completion cycle frees the slot first
    always_comb begin
        packet_d   = packet_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;
        if (frame_done) begin
            if (!valid_q || fetched) begin
                packet_d   = shift_d;
                valid_d    = 1'b1;
                overflow_d = 1'b0;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (fetched && valid_q) begin
            valid_d    = 1'b0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            clk_prev_q <= 1'b0;
            dat_prev_q <= 1'b0;
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            timer_q    <= '0;
            packet_q   <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            clk_prev_q <= clk_s;
            dat_prev_q <= dat_s;
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            timer_q    <= timer_d;
            packet_q   <= packet_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign packet   = packet_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_spmi.sv
`timescale 1ns / 100ps
// tb_spmi: scoreboard bench for the SPMI receiver. Stimulus pushes expected
// frames into a queue; a monitor pops and compares whenever a new frame appears.
module tb_spmi;
    import spmi_pkg::*;

    logic                  sysclk  = 1'b0;
    logic                  reset   = 1'b0;
    logic                  spmiclk = 1'b0;
    logic                  spmidat = 1'b0;
    logic                  fetched = 1'b0;
    logic [FRAME_BITS-1:0] packet;
    logic                  valid;
    logic                  overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [FRAME_BITS-1:0] exp_q[$];
    logic [FRAME_BITS-1:0] mon_exp;
    logic                  prev_valid = 1'b0;
    logic [FRAME_BITS-1:0] prev_pkt   = '0;

    spmi #(.SYNC_STAGES(2), .TIMEOUT(64)) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .spmiclk  (spmiclk),
        .spmidat  (spmidat),
        .fetched  (fetched),
        .packet   (packet),
        .valid    (valid),
        .overflow (overflow)
    );

    // 5 ns sysclk; all stimulus changes land on falling edges
    always #2.5 sysclk = ~sysclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a frame is presented when valid rises or packet changes while valid
    always @(negedge sysclk) begin
        if (!reset) begin
            prev_valid <= 1'b0;
            prev_pkt   <= '0;
        end else begin
            if (valid && (!prev_valid || packet != prev_pkt)) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_frame: got %h, expected none", packet);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (packet !== mon_exp) begin
                        n_fail++;
                        $display("FAIL frame: got %h, expected %h", packet, mon_exp);
                    end
                end
            end
            prev_valid <= valid;
            prev_pkt   <= packet;
        end
    end

    // SSC then 13 bits at a 45 ns period (20 ns low, 25 ns high)
    task automatic send_frame(input logic [FRAME_BITS-1:0] f, input bit accept,
                              input bit fetch_end);
        if (accept) exp_q.push_back(f);
        spmidat = 1'b1;
        #45;
        spmidat = 1'b0;
        #20;
        for (int i = FRAME_BITS - 1; i >= 0; i--) begin
            spmidat = f[i];
            #20;
            spmiclk = 1'b1;
            if (i != 0) begin
                #25;
            end else if (fetch_end) begin
                // fetched lands on the sysclk edge that sees the 13th rise
                #10;
                fetched = 1'b1;
                #5;
                fetched = 1'b0;
                #6;
                if (accept) check("latency", exp_q.size(), 0);
                #4;
            end else begin
                #21;
                if (accept) check("latency", exp_q.size(), 0);
                #4;
            end
            spmiclk = 1'b0;
        end
        spmidat = 1'b0;
        #20;
    endtask

    task automatic send_partial(input logic [FRAME_BITS-1:0] f, input int nbits);
        spmidat = 1'b1;
        #45;
        spmidat = 1'b0;
        #20;
        for (int i = 0; i < nbits; i++) begin
            spmidat = f[FRAME_BITS-1-i];
            #20;
            spmiclk = 1'b1;
            #25;
            spmiclk = 1'b0;
        end
        spmidat = 1'b0;
    endtask

    task automatic pulse_fetch();
        fetched = 1'b1;
        #5;
        fetched = 1'b0;
        #5;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset, then a malformed SSC (clock rises before data falls)
        #50;
        reset = 1'b1;
        #6;
        check("reset_packet", 32'(packet), 0);
        check("reset_valid", 32'(valid), 0);
        check("reset_overflow", 32'(overflow), 0);
        #4;
        spmidat = 1'b1;
        #20;
        spmiclk = 1'b1;
        #25;
        spmidat = 1'b0;
        #10;
        spmiclk = 1'b0;
        #120;
        #1;
        check("no_ssc_valid", 32'(valid), 0);
        #4;

        // 2: first frame
        send_frame(13'h02F5, 1'b1, 1'b0);
        #1;
        check("f1_valid", 32'(valid), 1);
        check("f1_overflow", 32'(overflow), 0);
        #4;

        // 3: second frame while full -> dropped
        send_frame(13'h1A05, 1'b0, 1'b0);
        #1;
        check("ovf_overflow", 32'(overflow), 1);
        check("ovf_packet", 32'(packet), 32'h02F5);
        check("ovf_valid", 32'(valid), 1);
        #4;
        pulse_fetch();
        #1;
        check("fetch_valid", 32'(valid), 0);
        check("fetch_overflow", 32'(overflow), 0);
        #4;

        // 4: accepted frame, then fetched on the completion cycle of the next
        send_frame(13'h1A05, 1'b1, 1'b0);
        send_frame(13'h0001, 1'b1, 1'b1);
        #1;
        check("fetch_cmpl_valid", 32'(valid), 1);
        check("fetch_cmpl_overflow", 32'(overflow), 0);
        #4;
        pulse_fetch();

        // 5: partial frame aborted by timeout, then a clean frame
        send_partial(13'h02F5, 6);
        #400;
        #1;
        check("timeout_valid", 32'(valid), 0);
        #4;
        send_frame(13'h02F5, 1'b1, 1'b0);

        // 6: reset mid-frame
        send_partial(13'h1A05, 7);
        reset = 1'b0;
        #20;
        #1;
        check("midreset_packet", 32'(packet), 0);
        check("midreset_valid", 32'(valid), 0);
        check("midreset_overflow", 32'(overflow), 0);
        #4;
        reset = 1'b1;
        #20;
        send_frame(13'h1A05, 1'b1, 1'b0);
        #1;
        check("final_valid", 32'(valid), 1);
        check("queue_drained", exp_q.size(), 0);
        #4;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
